// File: rtl/vc_arbiter_ctrl.sv
// Flow-control FSM and weighted round-robin drain arbiter for the two class FIFOs
// (VC0/VC1) feeding one downstream port; at most one word is moved per cycle.
module vc_arbiter_ctrl #(
   parameter int WIDTH = 10,
   parameter int UMB_W = 3,
   parameter int W0    = 3,
   parameter int W1    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic [UMB_W-1:0] umb_af_in,
   input  logic [UMB_W-1:0] umb_ae_in,
   input  logic             vc0_empty,
   input  logic             vc1_empty,
   input  logic [WIDTH-1:0] vc0_data,
   input  logic [WIDTH-1:0] vc1_data,
   input  logic             vc0_ovf,
   input  logic             vc1_ovf,
   input  logic             dn_afull,
   output logic             pop_vc0,
   output logic             pop_vc1,
   output logic             push_out,
   output logic [WIDTH-1:0] data_out,
   output logic             vc_out,
   output logic [UMB_W-1:0] umb_af_out,
   output logic [UMB_W-1:0] umb_ae_out,
   output logic [4:0]       state,
   output logic             idle_out,
   output logic             error_out
);

   // Handshake: a pop_vcN high during a cycle consumes the FIFO head on the next rising
   // edge; push_out is high for exactly one cycle per forwarded word, one cycle after its pop.

   typedef enum logic [4:0] {
      ST_RESET  = 5'b00001,
      ST_INIT   = 5'b00010,
      ST_IDLE   = 5'b00100,
      ST_ACTIVE = 5'b01000,
      ST_ERROR  = 5'b10000
   } state_t;

   localparam logic [2:0] WT0 = 3'(W0);
   localparam logic [2:0] WT1 = 3'(W1);

   state_t     st;
   state_t     st_nxt;
   logic       cur_vc;
   logic [2:0] run_cnt;

   logic       ovf;
   logic       pop_ok;
   logic       cur_ne;
   logic       oth_ne;
   logic [2:0] w_cur;
   logic       grant;
   logic       grant_vc;
   logic       nxt_cur;
   logic [2:0] nxt_cnt;

   assign ovf    = vc0_ovf | vc1_ovf;
   assign pop_ok = (st == ST_ACTIVE) && !dn_afull && !init && !ovf;

   // Weighted round robin: stay on the current class while its quota lasts, hand over
   // to a waiting class once it is used up, and keep streaming if nobody else waits.
   always_comb begin
      cur_ne   = cur_vc ? !vc1_empty : !vc0_empty;
      oth_ne   = cur_vc ? !vc0_empty : !vc1_empty;
      w_cur    = cur_vc ? WT1 : WT0;
      grant    = 1'b0;
      grant_vc = cur_vc;
      nxt_cur  = cur_vc;
      nxt_cnt  = run_cnt;
      if (cur_ne && (run_cnt < w_cur)) begin
         grant   = 1'b1;
         nxt_cnt = run_cnt + 3'd1;
      end else if (oth_ne) begin
         grant    = 1'b1;
         grant_vc = ~cur_vc;
         nxt_cur  = ~cur_vc;
         nxt_cnt  = 3'd1;
      end else if (cur_ne) begin
         grant   = 1'b1;
         nxt_cnt = w_cur;
      end
   end

   assign pop_vc0 = pop_ok & grant & ~grant_vc;
   assign pop_vc1 = pop_ok & grant &  grant_vc;

   // Overflow beats a reload request, which beats all ordinary transitions.
   always_comb begin
      st_nxt = st;
      case (st)
         ST_RESET: st_nxt = ST_INIT;
         ST_ERROR: st_nxt = ST_ERROR;
         ST_INIT, ST_IDLE, ST_ACTIVE: begin
            if (ovf) begin
               st_nxt = ST_ERROR;
            end else if (init) begin
               st_nxt = ST_INIT;
            end else begin
               case (st)
                  ST_INIT: st_nxt = ST_IDLE;
                  ST_IDLE: begin
                     if (!vc0_empty || !vc1_empty) st_nxt = ST_ACTIVE;
                  end
                  ST_ACTIVE: begin
                     if (vc0_empty && vc1_empty) st_nxt = ST_IDLE;
                  end
                  default: st_nxt = st;
               endcase
            end
         end
         default: st_nxt = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= ST_RESET;
         idle_out   <= 1'b0;
         error_out  <= 1'b0;
         cur_vc     <= 1'b0;
         run_cnt    <= 3'd0;
         push_out   <= 1'b0;
         data_out   <= '0;
         vc_out     <= 1'b0;
         umb_af_out <= '0;
         umb_ae_out <= '0;
      end else begin
         st        <= st_nxt;
         idle_out  <= (st_nxt == ST_IDLE);
         error_out <= (st_nxt == ST_ERROR);
         if ((st == ST_INIT) && init && !ovf) begin
            umb_af_out <= umb_af_in;
            umb_ae_out <= umb_ae_in;
         end
         if (pop_vc0 || pop_vc1) begin
            cur_vc   <= nxt_cur;
            run_cnt  <= nxt_cnt;
            data_out <= grant_vc ? vc1_data : vc0_data;
            vc_out   <= grant_vc;
            push_out <= 1'b1;
         end else begin
            push_out <= 1'b0;
         end
      end
   end

   assign state = st;

endmodule
